// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline and the hazard controller.
// The pipeline drives the master side and the controller takes the slave side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              valid_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic              RSuse_i;
  logic              RTuse_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic              RegWrite_i;
  logic              PCsrc_i;
  logic              Jump_i;
  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              IFIDFlush_o;
  logic              IDEXBubble_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output valid_i, RSaddr_i, RTaddr_i, RSuse_i, RTuse_i, RDaddr_i, RegWrite_i, PCsrc_i, Jump_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  valid_i, RSaddr_i, RTaddr_i, RSuse_i, RTuse_i, RDaddr_i, RegWrite_i, PCsrc_i, Jump_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard stall/flush sequencer for the 5-stage pipeline.
// Define HZ_PERF_EN to build the stall/redirect performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned WB_DIST = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned NReg   = 2 ** ADDR_W;
  localparam int unsigned SbW    = $clog2(WB_DIST + 1);
  localparam logic [SbW-1:0] SbLoad = SbW'(WB_DIST);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [SbW-1:0] cnt_q [NReg];
  logic [SbW-1:0] cnt_d [NReg];

  logic rs_pend, rt_pend, hazard, redirect, issue, record;

  always_comb begin
    rs_pend  = bus.RSuse_i && (bus.RSaddr_i != '0) && (cnt_q[bus.RSaddr_i] != '0);
    rt_pend  = bus.RTuse_i && (bus.RTaddr_i != '0) && (cnt_q[bus.RTaddr_i] != '0);
    hazard   = bus.valid_i & (rs_pend | rt_pend);
    redirect = bus.PCsrc_i | bus.Jump_i;
    issue    = bus.valid_i & ~hazard & ~redirect;
    record   = issue & bus.RegWrite_i & (bus.RDaddr_i != '0);
  end

  // A fresh load overrides the decrement; R0 is never tracked.
  always_comb begin
    for (int unsigned r = 0; r < NReg; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - SbW'(1) : '0;
      if (record && (bus.RDaddr_i == ADDR_W'(r))) begin
        cnt_d[r] = SbLoad;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    if (redirect) begin
      state_d = StFlush;
    end else if (hazard) begin
      state_d = StStall;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      for (int unsigned r = 0; r < NReg; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int unsigned r = 0; r < NReg; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Reset forces the pipeline to hold the PC and feed NOPs.
  always_comb begin
    if (!rst_i) begin
      bus.PCWrite_o    = 1'b0;
      bus.IFIDWrite_o  = 1'b0;
      bus.IFIDFlush_o  = 1'b1;
      bus.IDEXBubble_o = 1'b1;
    end else if (redirect) begin
      bus.PCWrite_o    = 1'b1;
      bus.IFIDWrite_o  = 1'b1;
      bus.IFIDFlush_o  = 1'b1;
      bus.IDEXBubble_o = 1'b1;
    end else if (hazard) begin
      bus.PCWrite_o    = 1'b0;
      bus.IFIDWrite_o  = 1'b0;
      bus.IFIDFlush_o  = 1'b0;
      bus.IDEXBubble_o = 1'b1;
    end else begin
      bus.PCWrite_o    = 1'b1;
      bus.IFIDWrite_o  = 1'b1;
      bus.IFIDFlush_o  = 1'b0;
      bus.IDEXBubble_o = 1'b0;
    end
  end

  assign bus.state_o = state_q;

`ifdef HZ_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && !redirect && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WB_DIST = 2).
// Control word is {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble} followed by state_o.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned CW = 16;

  localparam logic [3:0] RunC   = 4'b1100;
  localparam logic [3:0] StallC = 4'b0001;
  localparam logic [3:0] FlushC = 4'b1111;
  localparam logic [3:0] RstC   = 4'b0011;

`ifdef HZ_PERF_EN
  localparam logic [CW-1:0] ExpStall = 16'd4;
  localparam logic [CW-1:0] ExpFlush = 16'd1;
`else
  localparam logic [CW-1:0] ExpStall = 16'd0;
  localparam logic [CW-1:0] ExpFlush = 16'd0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .ADDR_W (AW),
    .WB_DIST(2),
    .CNT_W  (CW)
  ) u_dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [5:0] obs;
  assign obs = {bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o, bus.IDEXBubble_o, bus.state_o};

  task automatic set_in(input logic v, input logic [AW-1:0] rs, input logic rsu,
                        input logic [AW-1:0] rt, input logic rtu, input logic [AW-1:0] rd,
                        input logic rw, input logic br, input logic jmp);
    bus.valid_i    = v;
    bus.RSaddr_i   = rs;
    bus.RSuse_i    = rsu;
    bus.RTaddr_i   = rt;
    bus.RTuse_i    = rtu;
    bus.RDaddr_i   = rd;
    bus.RegWrite_i = rw;
    bus.PCsrc_i    = br;
    bus.Jump_i     = jmp;
  endtask

  task automatic nop();
    set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    nop();
    #2;
    n_checks++;
    if (obs !== {RstC, 2'd0}) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, {RstC, 2'd0});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL nop_run: got %b expected %b", obs, {RunC, 2'd0});
    end
  endtask

  task automatic test_raw_stall();
    set_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL producer: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd0}) begin
      n_fail++; $display("FAIL dep_stall1: got %b expected %b", obs, {StallC, 2'd0});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd1}) begin
      n_fail++; $display("FAIL dep_stall2: got %b expected %b", obs, {StallC, 2'd1});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd1}) begin
      n_fail++; $display("FAIL dep_issue: got %b expected %b", obs, {RunC, 2'd1});
    end
    tick();
    // R4 is pending but the slot is empty, so no stall.
    set_in(1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL nop_pending_src: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    nop();
    tick();
    tick();
  endtask

  task automatic test_r0();
    set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL write_r0: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL read_r0: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    nop();
    tick();
  endtask

  task automatic test_jump_over_stall();
    set_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL prod_r3: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (obs !== {FlushC, 2'd0}) begin
      n_fail++; $display("FAIL jump_beats_hazard: got %b expected %b", obs, {FlushC, 2'd0});
    end
    tick();
    nop();
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd2}) begin
      n_fail++; $display("FAIL state_flush: got %b expected %b", obs, {RunC, 2'd2});
    end
    tick();
    // R3 has drained through the redirect; R6 was never recorded.
    set_in(1'b1, 3'd6, 1'b1, 3'd3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL no_squashed_dest: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    nop();
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL wr5_a: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL wr5_b: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd0}) begin
      n_fail++; $display("FAIL rt5_stall1: got %b expected %b", obs, {StallC, 2'd0});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd1}) begin
      n_fail++; $display("FAIL rt5_stall2: got %b expected %b", obs, {StallC, 2'd1});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd1}) begin
      n_fail++; $display("FAIL rt5_issue: got %b expected %b", obs, {RunC, 2'd1});
    end
    tick();
    nop();
    tick();
    tick();
    n_checks++;
    if (bus.stall_cnt_o !== ExpStall) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected %0d", bus.stall_cnt_o, ExpStall);
    end
    n_checks++;
    if (bus.flush_cnt_o !== ExpFlush) begin
      n_fail++; $display("FAIL perf_flush: got %0d expected %0d", bus.flush_cnt_o, ExpFlush);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL prod_r3_b: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    set_in(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd0}) begin
      n_fail++; $display("FAIL mid_stall1: got %b expected %b", obs, {StallC, 2'd0});
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {StallC, 2'd1}) begin
      n_fail++; $display("FAIL mid_stall2: got %b expected %b", obs, {StallC, 2'd1});
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== {RstC, 2'd0}) begin
      n_fail++; $display("FAIL rst_async: got %b expected %b", obs, {RstC, 2'd0});
    end
    n_checks++;
    if ((bus.stall_cnt_o !== 16'd0) || (bus.flush_cnt_o !== 16'd0)) begin
      n_fail++;
      $display("FAIL perf_rst: got %0d/%0d expected 0/0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
    tick();
    #1;
    n_checks++;
    if (obs !== {RstC, 2'd0}) begin
      n_fail++; $display("FAIL rst_held: got %b expected %b", obs, {RstC, 2'd0});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== {RunC, 2'd0}) begin
      n_fail++; $display("FAIL post_rst_issue: got %b expected %b", obs, {RunC, 2'd0});
    end
    tick();
    nop();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw_stall();
    test_r0();
    test_jump_over_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Scoreboard-based stall/flush sequencer for the 5-stage, 8-register, 16-bit pipeline.
- Tracks in-flight register writes with per-register countdown counters. Stalls the IF/ID instruction while any source it reads is still pending.
- Squashes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Drives the PC, IF/ID and ID/EX write/flush controls. Replaces address-compare hazard logic with a sequenced controller.

Parameters:
- ADDR_W, 3, register address width (NREG = 2**ADDR_W).
- WB_DIST, 2, cycles from issue until the result is readable in ID (split-cycle register file); range 1..7.
- CNT_W, 16, width of the performance counters (optional feature).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  IF/ID holds a real instruction
- RSaddr_i  in  ADDR_W  source 1 of the IF/ID instruction (instr[12:10])
- RTaddr_i  in  ADDR_W  source 2 of the IF/ID instruction (instr[9:7])
- RSuse_i  in  1  IF/ID instruction reads RS
- RTuse_i  in  1  IF/ID instruction reads RT
- RDaddr_i  in  ADDR_W  destination of the IF/ID instruction, after RegDst mux
- RegWrite_i  in  1  IF/ID instruction writes RDaddr_i
- PCsrc_i  in  1  taken branch resolved in EX
- Jump_i  in  1  jump resolved in EX
- PCWrite_o  out  1  PC load enable
- IFIDWrite_o  out  1  IF/ID load enable
- IFIDFlush_o  out  1  IF/ID clear to NOP
- IDEXBubble_o  out  1  ID/EX loads NOP (control bits zero)
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
- stall_cnt_o  out  CNT_W  stall cycles (optional feature)
- flush_cnt_o  out  CNT_W  redirect events (optional feature)

Behaviour:
- Scoreboard:
  - cnt[r] is ceil(log2(WB_DIST+1)) bits per register.
  - Register 0 is hardwired zero: never tracked, never causes a hazard.
- hazard (combinational) = valid_i & ((RSuse_i & cnt[RSaddr_i]!=0 & RSaddr_i!=0) | (RTuse_i & cnt[RTaddr_i]!=0 & RTaddr_i!=0)).
- redirect = PCsrc_i | Jump_i.
- issue = valid_i & ~hazard & ~redirect.
- Each rising edge:
  - Every nonzero cnt decrements by 1.
  - If issue & RegWrite_i & RDaddr_i!=0, cnt[RDaddr_i] loads WB_DIST. The load takes priority over that register's decrement.
- Output priority:
  - redirect: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=1, IDEXBubble_o=1. The IF/ID instruction is squashed and its destination is not recorded.
  - else hazard: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=1.
  - else: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=0, IDEXBubble_o=0.
- Redirect beats hazard in the same cycle.
- Timing: a producer issued in cycle t is followed by a dependent in ID at t+1. The dependent sees cnt=WB_DIST, stalls WB_DIST cycles and issues at t+1+WB_DIST. With WB_DIST=2 that is 2 bubbles.
- FSM, registered, updated each edge from that cycle's decision:
  - any state -> FLUSH on redirect
  - -> STALL on hazard
  - -> RUN otherwise
  - state_o shows the action of the previous cycle.
- Reset (rst_i=0, any time including mid-stall):
  - All cnt cleared, state RUN, performance counters 0.
  - While rst_i=0, outputs are forced to PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=1, IDEXBubble_o=1.
  - The first cycle after release behaves as RUN with an empty scoreboard.
- valid_i=0: no hazard and no issue. Counters still decrement and outputs take the normal path.

Optional Feature:
- Macro HZ_PERF_EN.
- Defined:
  - stall_cnt_o increments on every hazard cycle that has no redirect.
  - flush_cnt_o increments on every redirect cycle.
  - Both saturate at 2**CNT_W-1 and clear only on reset.
- Undefined: both ports remain and are tied to 0; no counter flops are instantiated.

Test Plan:
- Reset release, NOP stream (valid_i=0) -> PCWrite_o=1, IFIDWrite_o=1, bubble/flush 0, state_o=0.
- Issue ADD writing R3; next cycle instr reads RS=R3 -> IDEXBubble_o=1, PCWrite_o=0 for exactly 2 cycles, state_o=1. The dependent issues on the 3rd cycle.
- Write R0 followed by a read of R0 -> no stall.
- Dependent stalled on R3 while Jump_i=1 in the same cycle -> IFIDFlush_o=1, IDEXBubble_o=1, PCWrite_o=1. R3 keeps counting; the squashed instr's destination is not recorded. state_o=2 next cycle.
- Back-to-back writes to R5 then R5 again, then a reader -> cnt[R5] reloads to 2; reader stalls 2 cycles after the second writer.
- rst_i low mid-stall with cnt[R3]=1 -> outputs forced immediately. After release, a reader of R3 issues without stall.
- With HZ_PERF_EN: the above sequence yields stall_cnt_o=4, flush_cnt_o=1. Without it, both read 0.
